wbm_host_loader: RTL and testbench

- Wishbone classic master: the initiator side of the accelerator's slave register/memory map.
- Converts 64-bit host-side commands into one or two 32-bit Wishbone beats:
  - mode/debug register writes;
  - query-patch, leaf and best-result memory reads and writes.
- Used in SoC-less bring-up and as a synthesizable bench driver in front of the slave controller.

---
 rtl/wbm_pkg.sv | 49 ++++
 rtl/wbm_beat.sv | 67 ++++++
 rtl/wbm_host_loader.sv | 134 +++++++++++++
 tb/tb_wbm_host_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// Shared types and address map for the Wishbone host loader.
// Base addresses mirror the slave controller's decode constants.
package wbm_pkg;

    typedef enum logic [1:0] {
        OP_REG_WR = 2'd0,
        OP_MEM_WR = 2'd1,
        OP_MEM_RD = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        RG_REG   = 2'd0,
        RG_QUERY = 2'd1,
        RG_LEAF  = 2'd2,
        RG_BEST  = 2'd3
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_GAP  = 3'd2,
        ST_HI   = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    localparam logic [31:0] BASE_REG   = 32'h3000_0000;
    localparam logic [31:0] BASE_QUERY = 32'h3100_0000;
    localparam logic [31:0] BASE_LEAF  = 32'h3200_0000;
    localparam logic [31:0] BASE_BEST  = 32'h3300_0000;

    // Encoding 3 is reserved and behaves as a read.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd0:    return OP_REG_WR;
            2'd1:    return OP_MEM_WR;
            default: return OP_MEM_RD;
        endcase
    endfunction

    function automatic logic [31:0] region_base(input region_e rg);
        case (rg)
            RG_REG:   return BASE_REG;
            RG_QUERY: return BASE_QUERY;
            RG_LEAF:  return BASE_LEAF;
            default:  return BASE_BEST;
        endcase
    endfunction

endpackage

// File: rtl/wbm_beat.sv
// Single-beat Wishbone engine: drives stb/adr/dat while i_go is high and
// assembles read data into a 64-bit word. Timeout counter under WBM_HOST_TIMEOUT_EN.
module wbm_beat #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_go,
    input  logic        i_we,
    input  logic        i_half,
    input  logic        i_clr,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    output logic        o_stb,
    output logic        o_we,
    output logic [3:0]  o_sel,
    output logic [31:0] o_adr,
    output logic [31:0] o_dat,
    output logic        o_done,
    output logic        o_timeout,
    output logic [63:0] o_rdata
);

    logic [63:0] r_rdata;
    logic        w_done;

    // Bus fields are gated by stb so the bus idles at all-zero.
    assign o_stb   = i_go;
    assign o_we    = i_go & i_we;
    assign o_sel   = i_go ? 4'hF : 4'h0;
    assign o_adr   = i_go ? i_adr : 32'h0;
    assign o_dat   = i_go ? i_dat : 32'h0;
    assign w_done  = i_go & i_wb_ack;
    assign o_done  = w_done;
    assign o_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 64'h0;
        end else if (i_clr) begin
            r_rdata <= 64'h0;
        end else if (w_done && !i_we) begin
            if (i_half) r_rdata[63:32] <= i_wb_dat;
            else        r_rdata[31:0]  <= i_wb_dat;
        end
    end

`ifdef WBM_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Cleared whenever stb is low, so every beat starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_cnt <= '0;
        else if (!i_go) r_cnt <= '0;
        else            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_timeout = i_go & ~i_wb_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/wbm_host_loader.sv
// Wishbone classic master turning 64-bit host commands into one or two 32-bit beats.
// Optional per-beat ack timeout enabled by defining WBM_HOST_TIMEOUT_EN.
module wbm_host_loader
    import wbm_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [1:0]        cmd_region_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [63:0]       cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [63:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    output logic              wbs_we_o,
    output logic [3:0]        wbs_sel_o,
    output logic [31:0]       wbs_adr_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [31:0]       wbs_dat_i,
    input  logic              wbs_ack_i
);

    state_e            r_state, w_next;
    op_e               r_op;
    region_e           r_region;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;

    logic        w_accept, w_go, w_half, w_we, w_clr;
    logic        w_done, w_timeout;
    logic [31:0] w_adr, w_dat;

    assign w_accept = cmd_valid_i && (r_state == ST_IDLE);
    assign w_go     = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_half   = (r_state == ST_HI);
    assign w_we     = (r_op != OP_MEM_RD);
    assign w_clr    = w_accept && (decode_op(cmd_op_i) != OP_MEM_RD);

    // Register space is word-per-address; memories pack two words per entry.
    always_comb begin
        w_adr = region_base(r_region);
        if (r_region == RG_REG)
            w_adr = w_adr + {31'h0, r_addr[0]};
        else
            w_adr = w_adr + (32'(r_addr) << 1) + {31'h0, w_half};
        w_dat = w_half ? r_wdata[63:32] : r_wdata[31:0];
    end

    wbm_beat #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_beat (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .i_go      (w_go),
        .i_we      (w_we),
        .i_half    (w_half),
        .i_clr     (w_clr),
        .i_adr     (w_adr),
        .i_dat     (w_dat),
        .i_wb_dat  (wbs_dat_i),
        .i_wb_ack  (wbs_ack_i),
        .o_stb     (wbs_stb_o),
        .o_we      (wbs_we_o),
        .o_sel     (wbs_sel_o),
        .o_adr     (wbs_adr_o),
        .o_dat     (wbs_dat_o),
        .o_done    (w_done),
        .o_timeout (w_timeout),
        .o_rdata   (rsp_rdata_o)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_op     <= OP_REG_WR;
            r_region <= RG_REG;
            r_addr   <= '0;
            r_wdata  <= 64'h0;
        end else if (w_accept) begin
            r_op     <= decode_op(cmd_op_i);
            r_region <= region_e'(cmd_region_i);
            r_addr   <= cmd_addr_i;
            r_wdata  <= cmd_wdata_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_LO;
            ST_LO: begin
                if (w_done)         w_next = (r_op == OP_REG_WR) ? ST_RSP : ST_GAP;
                else if (w_timeout) w_next = ST_RSP;
            end
            ST_GAP:  w_next = ST_HI;
            ST_HI:   if (w_done || w_timeout) w_next = ST_RSP;
            ST_RSP:  if (rsp_ready_i) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef WBM_HOST_TIMEOUT_EN
    logic r_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)     r_err <= 1'b0;
        else if (w_accept)  r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end

    assign rsp_err_o = r_err;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign rsp_valid_o = (r_state == ST_RSP);
    assign wbs_cyc_o   = w_go || (r_state == ST_GAP);

endmodule

// File: tb/tb_wbm_host_loader.sv
// Directed bench: slave model checks each beat against a scoreboard queue,
// responses are compared against expectations pushed when each command is issued.
module tb_wbm_host_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'd0, cmd_region = 2'd0;
    logic [15:0] cmd_addr = 16'h0;
    logic [63:0] cmd_wdata = 64'h0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [63:0] rsp_rdata;
    logic        cyc, stb, we, ack = 1'b0;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i = 32'h0;

    always #5 clk = ~clk;

    wbm_host_loader #(.ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_region_i(cmd_region), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .wbs_cyc_o(cyc), .wbs_stb_o(stb), .wbs_we_o(we), .wbs_sel_o(sel),
        .wbs_adr_o(adr), .wbs_dat_o(dat_o), .wbs_dat_i(dat_i), .wbs_ack_i(ack)
    );

    typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; logic chk_dat; } beat_t;
    typedef struct { logic [63:0] rdata; logic err; } rsp_t;

    beat_t       beat_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] rd_q[$];
    int checks = 0, errors = 0;
    int slv_delay = 0, slv_cnt = 0, gap_cnt = 0, stb_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic w, input logic cd);
        beat_t b;
        b.adr = a; b.dat = d; b.we = w; b.chk_dat = cd;
        beat_q.push_back(b);
    endtask

    // Slave: acks after slv_delay stall cycles; checks every stb cycle so
    // adr/dat/we must stay stable across the whole stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack = 1'b0; slv_cnt = 0;
        end else begin
            ack = 1'b0;
            if (cyc && !stb) gap_cnt++;
            if (cyc && stb) begin
                stb_cnt++;
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", {32'h0, adr}, 64'h0);
                end else begin
                    chk("beat_adr", {32'h0, adr}, {32'h0, beat_q[0].adr});
                    chk("beat_we", {63'h0, we}, {63'h0, beat_q[0].we});
                    chk("beat_sel", {60'h0, sel}, 64'hF);
                    if (beat_q[0].chk_dat) chk("beat_dat", {32'h0, dat_o}, {32'h0, beat_q[0].dat});
                    if (slv_cnt >= slv_delay) begin
                        ack = 1'b1;
                        dat_i = (rd_q.size() != 0) ? rd_q.pop_front() : $urandom;
                        void'(beat_q.pop_front());
                        slv_cnt = 0;
                    end else begin
                        slv_cnt++;
                    end
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] rg,
                           input logic [15:0] a, input logic [63:0] wd, input int d,
                           input int rdy_wait, input logic [63:0] exp_rd, input logic exp_err,
                           input int exp_lat, input int exp_gap, input int exp_stb,
                           input int exp_left);
        int   lat;
        rsp_t e;
        e.rdata = exp_rd; e.err = exp_err;
        rsp_q.push_back(e);
        slv_delay = d; gap_cnt = 0; stb_cnt = 0;
        @(negedge clk);
        chk({tag, "_ready"}, {63'h0, cmd_ready}, 64'h1);
        cmd_valid = 1'b1; cmd_op = op; cmd_region = rg; cmd_addr = a; cmd_wdata = wd;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        for (int k = 0; k < rdy_wait; k++) begin
            chk({tag, "_hold_valid"}, {63'h0, rsp_valid}, 64'h1);
            chk({tag, "_hold_ready"}, {63'h0, cmd_ready}, 64'h0);
            @(negedge clk);
        end
        e = rsp_q.pop_front();
        chk({tag, "_rsp_valid"}, {63'h0, rsp_valid}, 64'h1);
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, {63'h0, rsp_err}, {63'h0, e.err});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_ready"}, {62'h0, cmd_ready, busy}, 64'h2);
        chk({tag, "_rsp_drop"}, {63'h0, rsp_valid}, 64'h0);
        chk({tag, "_gap"}, 64'(gap_cnt), 64'(exp_gap));
        chk({tag, "_stb_cycles"}, 64'(stb_cnt), 64'(exp_stb));
        chk({tag, "_beats_left"}, 64'(beat_q.size()), 64'(exp_left));
        beat_q.delete();
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_bus", {cyc, stb, we, sel, adr, dat_o}, 64'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, busy, cmd_ready}, 64'h1);
        chk("rst_rdata", rsp_rdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // REG_WR debug, slave acks one cycle after stb
        push_beat(32'h3000_0001, 32'h0000_0001, 1'b1, 1'b1);
        run_cmd("reg_dbg", 2'd0, 2'd0, 16'd1, 64'h1, 1, 0, 64'h0, 1'b0, 3, 0, 2, 0);

        // MEM_RD QUERY addr 1
        push_beat(32'h3100_0002, 32'h0, 1'b0, 1'b0);
        push_beat(32'h3100_0003, 32'h0, 1'b0, 1'b0);
        rd_q.push_back(32'hDEAD_BEEF); rd_q.push_back(32'h0000_1010);
        run_cmd("rd_query", 2'd2, 2'd1, 16'd1, 64'h0, 0, 0, 64'h0000_1010_DEAD_BEEF, 1'b0, 4, 1, 2, 0);

        // MEM_WR LEAF addr 3; write clears the previous read data
        push_beat(32'h3200_0006, 32'h7654_3210, 1'b1, 1'b1);
        push_beat(32'h3200_0007, 32'hFEDC_BA98, 1'b1, 1'b1);
        run_cmd("wr_leaf", 2'd1, 2'd2, 16'd3, 64'hFEDC_BA98_7654_3210, 0, 0, 64'h0, 1'b0, 4, 1, 2, 0);

        // 5-cycle stall per beat and 3-cycle response back-pressure
        push_beat(32'h3300_000A, 32'h89AB_CDEF, 1'b1, 1'b1);
        push_beat(32'h3300_000B, 32'h0123_4567, 1'b1, 1'b1);
        run_cmd("wr_stall", 2'd1, 2'd3, 16'd5, 64'h0123_4567_89AB_CDEF, 5, 3, 64'h0, 1'b0, 14, 1, 12, 0);

        // Reserved op behaves as MEM_RD; top of address range
        push_beat(32'h3101_FFFE, 32'h0, 1'b0, 1'b0);
        push_beat(32'h3101_FFFF, 32'h0, 1'b0, 1'b0);
        rd_q.push_back(32'h1111_2222); rd_q.push_back(32'h3333_4444);
        run_cmd("rd_rsvd_max", 2'd3, 2'd1, 16'hFFFF, 64'h0, 2, 1, 64'h3333_4444_1111_2222, 1'b0, 8, 1, 6, 0);

        // Reset pulsed during the HI beat
        push_beat(32'h3100_0000, 32'h0, 1'b0, 1'b0);
        push_beat(32'h3100_0001, 32'h0, 1'b0, 1'b0);
        rd_q.push_back(32'hAAAA_5555); rd_q.push_back(32'h5555_AAAA);
        slv_delay = 3;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_region = 2'd1; cmd_addr = 16'd0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (n < 50 && !(stb && adr == 32'h3100_0001)) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_hi", 64'(n < 50), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_bus", {61'h0, cyc, stb, rsp_valid}, 64'h0);
        chk("rst_mid_ready", {62'h0, cmd_ready, busy}, 64'h2);
        beat_q.delete(); rd_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_rsp", {62'h0, rsp_valid, cyc}, 64'h0);
        push_beat(32'h3000_0000, 32'h0000_0005, 1'b1, 1'b1);
        run_cmd("reg_mode_after_rst", 2'd0, 2'd0, 16'd0, 64'h5, 0, 0, 64'h0, 1'b0, 2, 0, 1, 0);

`ifdef WBM_HOST_TIMEOUT_EN
        // No ack: LO beat abandoned after 4 stb cycles, HI beat skipped
        push_beat(32'h3300_0000, 32'h0, 1'b0, 1'b0);
        run_cmd("rd_timeout", 2'd2, 2'd3, 16'd0, 64'h0, 1000, 0, 64'h0, 1'b1, 5, 0, 4, 1);
        push_beat(32'h3000_0001, 32'h0000_0002, 1'b1, 1'b1);
        run_cmd("reg_after_timeout", 2'd0, 2'd0, 16'd1, 64'h2, 0, 0, 64'h0, 1'b0, 2, 0, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
